// File: rtl/cpu_debug_ctrl.sv
// Run/halt/step debug controller: front-panel buttons, CPU sync/address breakpoints, NMI pulse, monitor register window.
// Optional macro CPU_DEBUG_CYCLE_COUNT_EN adds a 24-bit instruction counter readable through the window.
module cpu_debug_ctrl #(
  parameter int         NUM_BP        = 4,
  parameter logic [7:0] WIN_BASE      = 8'hE0,
  parameter int         STEP_OVERHEAD = 2,
  parameter int         NMI_LEN       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        A,
  input  logic              write,
  input  logic [7:0]        Din,
  output logic [7:0]        Dout,
  output logic              win_sel,
  input  logic [15:0]       cpu_addr,
  input  logic              sync,
  input  logic              b_step,
  input  logic              b_runhalt,
  input  logic              b_reset,
  output logic              nmiN,
  output logic              stopped,
  output logic [NUM_BP-1:0] bp_hit
);

  localparam int BP_END = 4 + 2 * NUM_BP;
`ifdef CPU_DEBUG_CYCLE_COUNT_EN
  localparam int WIN_SIZE = BP_END + 3;
`else
  localparam int WIN_SIZE = BP_END;
`endif
  localparam logic [7:0] WIN_SIZE_B = 8'(WIN_SIZE);
  localparam logic [9:0] OVH        = 10'(STEP_OVERHEAD);
  localparam int         NW         = $clog2(NMI_LEN + 1);

  typedef enum logic [2:0] {S_RUN, S_STOPPED, S_ARMED, S_STEPPING, S_RESYNC} state_t;

  state_t              state, state_nx;
  logic                sync_q;
  logic [7:0]          step_count;
  logic [NUM_BP-1:0]   bp_en;
  logic [15:0]         bp_addr [NUM_BP];
  logic [9:0]          step_cnt;
  logic [NW-1:0]       nmi_cnt;
  logic [7:0]          rd_data;

  logic [8:0]          off9;
  logic [7:0]          off;
  logic                wr_en, wr_cmd, sync_rise;
  logic [NUM_BP-1:0]   match, hit_set;
  logic [9:0]          step_target, step_next;
  logic                nmi_req, cnt_clr;

  assign off9      = {1'b0, A} - {1'b0, WIN_BASE};
  assign off       = off9[7:0];
  assign win_sel   = !off9[8] && (off < WIN_SIZE_B);
  assign wr_en     = write && win_sel;
  assign wr_cmd    = wr_en && (off == 8'd0);
  assign sync_rise = sync && !sync_q;

  always_comb begin
    for (int i = 0; i < NUM_BP; i++)
      match[i] = bp_en[i] && (cpu_addr == bp_addr[i]);
  end

  // step_count of 0 behaves as 1; counter saturates rather than wrapping
  assign step_target = OVH + ((step_count == 8'd0) ? 10'd1 : {2'b00, step_count});
  assign step_next   = (step_cnt == 10'h3FF) ? step_cnt : step_cnt + 10'd1;

  always_comb begin
    state_nx = state;
    nmi_req  = 1'b0;
    hit_set  = '0;
    cnt_clr  = 1'b0;
    case (state)
      S_RUN: begin
        if (sync_rise && |match) begin
          hit_set  = match;
          nmi_req  = 1'b1;
          state_nx = S_STOPPED;
        end
        if (b_step || b_runhalt) begin
          nmi_req  = 1'b1;
          state_nx = S_STOPPED;
        end
      end
      S_STOPPED: begin
        if (b_reset)                    state_nx = S_RESYNC;
        else if (b_runhalt)             state_nx = S_RUN;
        else if (b_step)                state_nx = S_ARMED;
        else if (wr_cmd && Din[4])      state_nx = S_RUN;
      end
      S_ARMED: begin
        if (b_reset) state_nx = S_RUN;
        else if (wr_cmd && Din[5]) begin
          state_nx = S_STEPPING;
          cnt_clr  = 1'b1;
        end
      end
      S_STEPPING: begin
        if (b_reset) state_nx = S_RUN;
        else if (sync_rise) begin
          if (step_cnt >= OVH && |match) hit_set = match;
          if ((step_cnt >= OVH && |match) || step_next >= step_target) begin
            nmi_req  = 1'b1;
            state_nx = S_STOPPED;
          end
        end
      end
      S_RESYNC: begin
        if (b_reset) state_nx = S_RUN;
        else if (sync_rise) begin
          nmi_req  = 1'b1;
          state_nx = S_STOPPED;
        end
      end
      default: state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RUN;
      sync_q   <= 1'b0;
      step_cnt <= '0;
      nmi_cnt  <= '0;
      bp_hit   <= '0;
    end else begin
      state  <= state_nx;
      sync_q <= sync;
      if (cnt_clr) step_cnt <= '0;
      else if (state == S_STEPPING && sync_rise) step_cnt <= step_next;
      // requests arriving while the pulse is active are dropped
      if (nmi_cnt != '0) nmi_cnt <= nmi_cnt - 1'b1;
      else if (nmi_req) nmi_cnt <= NW'(NMI_LEN);
      bp_hit <= ((wr_cmd && Din[7]) ? '0 : bp_hit) | hit_set;
    end
  end

  assign nmiN    = (nmi_cnt == '0);
  assign stopped = (state == S_STOPPED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_count <= 8'd1;
      bp_en      <= '0;
      for (int i = 0; i < NUM_BP; i++) bp_addr[i] <= '0;
    end else if (wr_en) begin
      if (off == 8'd1) step_count <= Din;
      if (off == 8'd2) bp_en <= Din[NUM_BP-1:0];
      for (int i = 0; i < NUM_BP; i++) begin
        if (off == 8'(4 + 2 * i)) bp_addr[i][7:0]  <= Din;
        if (off == 8'(5 + 2 * i)) bp_addr[i][15:8] <= Din;
      end
    end
  end

`ifdef CPU_DEBUG_CYCLE_COUNT_EN
  logic [23:0] icnt;
  logic [15:0] icnt_hi;

  // reading the low byte snapshots the upper bytes for a coherent multi-byte read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt    <= '0;
      icnt_hi <= '0;
    end else begin
      if (wr_cmd && Din[6]) icnt <= '0;
      else if (sync_rise && (state == S_RUN || state == S_STEPPING)) icnt <= icnt + 24'd1;
      if (win_sel && off == 8'(BP_END)) icnt_hi <= icnt[23:8];
    end
  end
`endif

  always_comb begin
    rd_data = 8'h00;
    if (win_sel) begin
      case (off)
        8'd0: rd_data = {stopped, state == S_ARMED, |bp_hit, 5'b00000};
        8'd1: rd_data = step_count;
        8'd2: rd_data = 8'(bp_en);
        8'd3: rd_data = 8'(bp_hit);
        default: begin
          for (int i = 0; i < NUM_BP; i++) begin
            if (off == 8'(4 + 2 * i)) rd_data = bp_addr[i][7:0];
            if (off == 8'(5 + 2 * i)) rd_data = bp_addr[i][15:8];
          end
`ifdef CPU_DEBUG_CYCLE_COUNT_EN
          if (off == 8'(BP_END))     rd_data = icnt[7:0];
          if (off == 8'(BP_END + 1)) rd_data = icnt_hi[7:0];
          if (off == 8'(BP_END + 2)) rd_data = icnt_hi[15:8];
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Dout <= 8'h00;
    else        Dout <= rd_data;
  end

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Self-checking bench for cpu_debug_ctrl with NUM_BP=4, WIN_BASE=E0, STEP_OVERHEAD=2, NMI_LEN=8.
module tb_cpu_debug_ctrl;
  localparam logic [7:0] WB = 8'hE0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  A = 8'h00, Din = 8'h00, Dout;
  logic        write = 1'b0, win_sel;
  logic [15:0] cpu_addr = 16'h0000;
  logic        sync = 1'b0, b_step = 1'b0, b_runhalt = 1'b0, b_reset = 1'b0;
  logic        nmiN, stopped;
  logic [3:0]  bp_hit;

  int total = 0, bad = 0;
  int nmi_pulses = 0, nmi_last_len = 0, nmi_run = 0;

  cpu_debug_ctrl #(.NUM_BP(4), .WIN_BASE(WB), .STEP_OVERHEAD(2), .NMI_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .write(write), .Din(Din), .Dout(Dout),
    .win_sel(win_sel), .cpu_addr(cpu_addr), .sync(sync), .b_step(b_step),
    .b_runhalt(b_runhalt), .b_reset(b_reset), .nmiN(nmiN), .stopped(stopped),
    .bp_hit(bp_hit)
  );

  always #5 clk = ~clk;

  // measures completed NMI pulses and their length in clocks
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) nmi_run <= 0;
    else if (!nmiN) nmi_run <= nmi_run + 1;
    else if (nmi_run != 0) begin
      nmi_last_len <= nmi_run;
      nmi_pulses   <= nmi_pulses + 1;
      nmi_run      <= 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic reg_wr(input int o, input logic [7:0] d);
    A = WB + 8'(o); Din = d; write = 1'b1;
    cyc(1);
    write = 1'b0;
  endtask

  task automatic reg_rd(input int o, output logic [7:0] d);
    A = WB + 8'(o);
    cyc(1);
    d = Dout;
  endtask

  task automatic press(input int which);
    b_step = (which == 0); b_runhalt = (which == 1); b_reset = (which == 2);
    cyc(1);
    b_step = 1'b0; b_runhalt = 1'b0; b_reset = 1'b0;
  endtask

  task automatic sync_edge(input logic [15:0] a);
    cpu_addr = a; sync = 1'b1;
    cyc(1);
    sync = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    logic [7:0] d, e;
    total++; if (nmiN !== 1'b1 || stopped !== 1'b0) begin bad++; $display("FAIL reset_out nmiN=%b stopped=%b exp 1 0", nmiN, stopped); end
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    for (int o = 0; o < 12; o++) begin
      reg_rd(o, d);
      e = (o == 1) ? 8'h01 : 8'h00;
      total++; if (d !== e) begin bad++; $display("FAIL reset_rd off=%0d got=%h exp=%h", o, d, e); end
    end
  endtask

  task automatic test_win_sel();
    logic e12;
`ifdef CPU_DEBUG_CYCLE_COUNT_EN
    e12 = 1'b1;
`else
    e12 = 1'b0;
`endif
    A = WB + 8'd11; #1;
    total++; if (win_sel !== 1'b1) begin bad++; $display("FAIL win_last got=%b exp=1", win_sel); end
    A = WB + 8'd12; #1;
    total++; if (win_sel !== e12) begin bad++; $display("FAIL win_past got=%b exp=%b", win_sel, e12); end
    A = WB - 8'd1; #1;
    total++; if (win_sel !== 1'b0) begin bad++; $display("FAIL win_below got=%b exp=0", win_sel); end
    cyc(1);
  endtask

  task automatic test_runhalt();
    int p;
    p = nmi_pulses;
    b_runhalt = 1'b1;
    total++; if (nmiN !== 1'b1) begin bad++; $display("FAIL rh_pre nmiN=%b exp=1", nmiN); end
    cyc(1);
    b_runhalt = 1'b0;
    total++; if (nmiN !== 1'b0 || stopped !== 1'b1) begin bad++; $display("FAIL rh_start nmiN=%b stopped=%b exp 0 1", nmiN, stopped); end
    cyc(7);
    total++; if (nmiN !== 1'b0) begin bad++; $display("FAIL rh_clk8 nmiN=%b exp=0", nmiN); end
    cyc(1);
    total++; if (nmiN !== 1'b1) begin bad++; $display("FAIL rh_clk9 nmiN=%b exp=1", nmiN); end
    cyc(2);
    total++; if (nmi_pulses !== p + 1 || nmi_last_len !== 8) begin bad++; $display("FAIL rh_pulse n=%0d len=%0d exp %0d 8", nmi_pulses, nmi_last_len, p + 1); end
    press(1);
    cyc(12);
    total++; if (stopped !== 1'b0 || nmi_pulses !== p + 1) begin bad++; $display("FAIL rh_resume stopped=%b n=%0d exp 0 %0d", stopped, nmi_pulses, p + 1); end
  endtask

  task automatic do_step(input int sc, input string nm);
    int n, p;
    logic [7:0] d;
    reg_wr(1, 8'(sc));
    reg_rd(1, d);
    total++; if (d !== 8'(sc)) begin bad++; $display("FAIL %s_sc got=%h exp=%h", nm, d, 8'(sc)); end
    press(0);
    reg_rd(0, d);
    total++; if (d !== 8'h40) begin bad++; $display("FAIL %s_armed got=%h exp=40", nm, d); end
    reg_wr(0, 8'h20);
    n = 2 + ((sc == 0) ? 1 : sc);
    p = nmi_pulses;
    for (int k = 0; k < n - 1; k++) sync_edge(16'($urandom));
    cyc(12);
    total++; if (stopped !== 1'b0 || nmi_pulses !== p) begin bad++; $display("FAIL %s_early stopped=%b n=%0d exp 0 %0d edges=%0d", nm, stopped, nmi_pulses, p, n - 1); end
    sync_edge(16'($urandom));
    total++; if (stopped !== 1'b1 || nmiN !== 1'b0) begin bad++; $display("FAIL %s_stop stopped=%b nmiN=%b exp 1 0 edges=%0d", nm, stopped, nmiN, n); end
    cyc(12);
    total++; if (nmi_pulses !== p + 1) begin bad++; $display("FAIL %s_pulse n=%0d exp=%0d", nm, nmi_pulses, p + 1); end
  endtask

  task automatic test_step();
    press(1);
    cyc(12);
    do_step(3, "step3");
  endtask

  task automatic test_step_random();
    repeat (4) do_step($urandom_range(0, 6), "step_rnd");
  endtask

  task automatic test_bp_directed();
    logic [7:0] d;
    reg_wr(8, 8'h12); reg_wr(9, 8'hC0);
    reg_wr(2, 8'hFF);
    reg_rd(2, d);
    total++; if (d !== 8'h0F) begin bad++; $display("FAIL bp_en_mask got=%h exp=0F", d); end
    reg_wr(2, 8'h04);
    reg_rd(9, d);
    total++; if (d !== 8'hC0) begin bad++; $display("FAIL bp2_hi got=%h exp=C0", d); end
    reg_wr(0, 8'h10);
    total++; if (stopped !== 1'b0) begin bad++; $display("FAIL bp_resume stopped=%b exp=0", stopped); end
    sync_edge(16'h1234);
    total++; if (stopped !== 1'b0) begin bad++; $display("FAIL bp_nomatch stopped=%b exp=0", stopped); end
    sync_edge(16'hC012);
    total++; if (bp_hit !== 4'b0100 || stopped !== 1'b1 || nmiN !== 1'b0) begin bad++; $display("FAIL bp_hit got=%b stopped=%b nmiN=%b exp 0100 1 0", bp_hit, stopped, nmiN); end
    reg_rd(0, d);
    total++; if (d !== 8'hA0) begin bad++; $display("FAIL bp_status got=%h exp=A0", d); end
    reg_wr(0, 8'h80);
    total++; if (bp_hit !== 4'b0000) begin bad++; $display("FAIL bp_clear got=%b exp=0000", bp_hit); end
    reg_wr(2, 8'h00);
    cyc(12);
  endtask

  task automatic test_bp_random();
    logic [15:0] bpa [4];
    logic [15:0] a;
    logic [3:0]  en, ex;
    int p, j;
    bit done;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 4; i++) bpa[i] = 16'($urandom);
      if (it % 2 == 1) bpa[3] = bpa[1];
      for (int i = 0; i < 4; i++) begin
        reg_wr(4 + 2 * i, bpa[i][7:0]);
        reg_wr(5 + 2 * i, bpa[i][15:8]);
      end
      en = 4'($urandom_range(1, 15));
      reg_wr(2, 8'(en));
      reg_wr(0, 8'h80);
      reg_wr(0, 8'h10);
      p = nmi_pulses;
      done = 1'b0;
      for (int k = 0; k < 21 && !done; k++) begin
        if (k == 20) begin
          j = 0;
          while (!en[j]) j++;
          a = bpa[j];
        end else if ($urandom_range(0, 2) == 0) a = bpa[$urandom_range(0, 3)];
        else a = 16'($urandom);
        ex = '0;
        for (int i = 0; i < 4; i++) if (en[i] && bpa[i] == a) ex[i] = 1'b1;
        sync_edge(a);
        if (ex != 4'b0000) begin
          done = 1'b1;
          total++; if (bp_hit !== ex || stopped !== 1'b1) begin bad++; $display("FAIL bp_rnd_hit it=%0d addr=%h got=%b stopped=%b exp=%b 1", it, a, bp_hit, stopped, ex); end
        end else begin
          total++; if (stopped !== 1'b0) begin bad++; $display("FAIL bp_rnd_spurious it=%0d addr=%h stopped=%b exp=0", it, a, stopped); end
        end
      end
      cyc(12);
      total++; if (nmi_pulses !== p + 1) begin bad++; $display("FAIL bp_rnd_pulse it=%0d n=%0d exp=%0d", it, nmi_pulses, p + 1); end
    end
    reg_wr(0, 8'h80);
    reg_wr(2, 8'h00);
  endtask

  task automatic test_bp_same_edge_write();
    logic [7:0] d;
    reg_wr(4, 8'h5A); reg_wr(5, 8'h5A);
    reg_wr(2, 8'h01);
    reg_wr(0, 8'h10);
    A = WB + 8'd2; Din = 8'h00; write = 1'b1; cpu_addr = 16'h5A5A; sync = 1'b1;
    cyc(1);
    write = 1'b0; sync = 1'b0;
    cyc(1);
    total++; if (bp_hit !== 4'b0001 || stopped !== 1'b1) begin bad++; $display("FAIL same_edge_hit got=%b stopped=%b exp 0001 1", bp_hit, stopped); end
    reg_rd(2, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL same_edge_en got=%h exp=00", d); end
    cyc(12);
    reg_wr(0, 8'h90);
    sync_edge(16'h5A5A);
    total++; if (stopped !== 1'b0 || bp_hit !== 4'b0000) begin bad++; $display("FAIL same_edge_after stopped=%b hit=%b exp 0 0000", stopped, bp_hit); end
  endtask

  task automatic test_resync();
    int p;
    logic [7:0] d;
    press(1);
    cyc(12);
    p = nmi_pulses;
    press(2);
    cyc(12);
    total++; if (stopped !== 1'b0 || nmi_pulses !== p) begin bad++; $display("FAIL resync_wait stopped=%b n=%0d exp 0 %0d", stopped, nmi_pulses, p); end
    sync_edge(16'($urandom));
    total++; if (stopped !== 1'b1 || nmiN !== 1'b0) begin bad++; $display("FAIL resync_stop stopped=%b nmiN=%b exp 1 0", stopped, nmiN); end
    cyc(12);
    press(0);
    press(2);
    cyc(12);
    total++; if (stopped !== 1'b0 || nmi_pulses !== p + 1) begin bad++; $display("FAIL armed_reset stopped=%b n=%0d exp 0 %0d", stopped, nmi_pulses, p + 1); end
    reg_rd(0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL armed_reset_status got=%h exp=00", d); end
    press(1);
    total++; if (stopped !== 1'b1) begin bad++; $display("FAIL armed_reset_run stopped=%b exp=1", stopped); end
    cyc(12);
  endtask

  task automatic test_back_to_back();
    int p;
    logic [7:0] d;
    reg_wr(0, 8'h10);
    p = nmi_pulses;
    press(0);
    cyc(1);
    press(0);
    cyc(12);
    total++; if (nmi_pulses !== p + 1 || nmi_last_len !== 8) begin bad++; $display("FAIL b2b_step n=%0d len=%0d exp %0d 8", nmi_pulses, nmi_last_len, p + 1); end
    reg_rd(0, d);
    total++; if (d !== 8'h40) begin bad++; $display("FAIL b2b_armed got=%h exp=40", d); end
    press(2);
    b_step = 1'b1; b_runhalt = 1'b1;
    cyc(1);
    b_step = 1'b0; b_runhalt = 1'b0;
    total++; if (stopped !== 1'b1) begin bad++; $display("FAIL both_btn stopped=%b exp=1", stopped); end
    cyc(12);
    total++; if (nmi_pulses !== p + 2 || nmi_last_len !== 8) begin bad++; $display("FAIL both_btn_pulse n=%0d len=%0d exp %0d 8", nmi_pulses, nmi_last_len, p + 2); end
    press(1);
    press(1);
    cyc(2);
    press(1);
    press(1);
    total++; if (stopped !== 1'b1) begin bad++; $display("FAIL ignore_stop stopped=%b exp=1", stopped); end
    cyc(14);
    total++; if (nmi_pulses !== p + 3 || nmi_last_len !== 8) begin bad++; $display("FAIL ignore_req n=%0d len=%0d exp %0d 8", nmi_pulses, nmi_last_len, p + 3); end
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    reg_wr(1, 8'h07);
    reg_wr(0, 8'h10);
    press(1);
    cyc(3);
    total++; if (nmiN !== 1'b0) begin bad++; $display("FAIL arst_pre nmiN=%b exp=0", nmiN); end
    rst_n = 1'b0;
    #1;
    total++; if (nmiN !== 1'b1 || stopped !== 1'b0) begin bad++; $display("FAIL arst_release nmiN=%b stopped=%b exp 1 0", nmiN, stopped); end
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    reg_rd(1, d);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL arst_sc got=%h exp=01", d); end
  endtask

  initial begin
    test_reset();
    test_win_sel();
    test_runhalt();
    test_step();
    test_step_random();
    test_bp_directed();
    test_bp_random();
    test_bp_same_edge_write();
    test_resync();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
